cpu_ctrl: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. It fetches instruction bytes from program memory over a req/ack handshake and drives the primary register file's `store`/`rEN`/`wEN`/`in` controls. It also captures register values read onto the data bus for an output port. It sits directly upstream of the register file and is the only block that commands it.

---
 rtl/cpu_ctrl.sv | 152 +++++++++++++++
 tb/tb_cpu_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU: fetches bytes over a
// req/ack handshake and drives the register file's select/enable/write-data controls.
module cpu_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [2:0] reg_sel,
  output logic       reg_ren,
  output logic       reg_wen,
  output logic [7:0] reg_wdata,
  input  logic [7:0] bus_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXEC,
    S_HALT
  } state_e;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_OUT = 3'b010;
  localparam logic [2:0] OP_JMP = 3'b011;
  localparam logic [2:0] OP_HLT = 3'b111;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:2] ir_q, ir_d;
  logic [7:0] opnd_q, opnd_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       illegal_q, illegal_d;

  logic [2:0] opcode;
  logic [2:0] reg_r;

  assign opcode = ir_q[7:5];
  assign reg_r  = ir_q[4:2];

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every one samples pre-edge values.
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      opnd_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      opnd_q      <= opnd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    opnd_d      = opnd_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    illegal_d   = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata[7:2];
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP:         state_d = S_FETCH;
          OP_LDI, OP_JMP: state_d = S_OPERAND;
          OP_OUT:         state_d = S_EXEC;
          OP_HLT:         state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_OPERAND: begin
        if (mem_ack) begin
          opnd_d  = mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (opcode == OP_OUT) begin
          out_data_d  = bus_in;
          out_valid_d = 1'b1;
        end
        if (opcode == OP_JMP) pc_d = opnd_q;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates the handshake and register enables combinationally, even mid-transfer.
  always_comb begin
    mem_req   = 1'b0;
    reg_ren   = 1'b0;
    reg_wen   = 1'b0;
    reg_sel   = '0;
    reg_wdata = '0;
    if (!rst) begin
      case (state_q)
        S_FETCH, S_OPERAND: mem_req = 1'b1;
        S_EXEC: begin
          if (opcode == OP_LDI) begin
            reg_wen   = 1'b1;
            reg_sel   = reg_r;
            reg_wdata = opnd_q;
          end else if (opcode == OP_OUT) begin
            reg_ren = 1'b1;
            reg_sel = reg_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: an instruction-level model expands each instruction into
// the expected per-cycle trace, which also supplies the memory/bus stimulus.
module tb_cpu_ctrl;

  localparam logic [7:0] RESET_PC = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] bus_in = 8'h00;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [2:0] reg_sel;
  logic       reg_ren;
  logic       reg_wen;
  logic [7:0] reg_wdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic       illegal;

  always #5 clk = ~clk;

  cpu_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .reg_sel  (reg_sel),
    .reg_ren  (reg_ren),
    .reg_wen  (reg_wen),
    .reg_wdata(reg_wdata),
    .bus_in   (bus_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .halted   (halted),
    .illegal  (illegal)
  );

  // One clock cycle: inputs to drive plus every output value expected in that cycle.
  typedef struct {
    bit         chk;
    bit         rst;
    bit         ack;
    logic [7:0] rdata;
    logic [7:0] bus;
    bit         req;
    logic [7:0] addr;
    bit         ren;
    bit         wen;
    logic [2:0] sel;
    logic [7:0] wdata;
    logic [7:0] od;
    bit         ov;
    bit         hlt;
    bit         ill;
  } cyc_t;

  cyc_t       q[$];
  logic [7:0] mem[256];

  // Architectural model state.
  logic [7:0] m_pc;
  logic [7:0] m_od;
  bit         m_ov_pending;
  bit         m_hlt;
  bit         m_ill;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] rnd();
    return 8'($urandom);
  endfunction

  function automatic cyc_t snap();
    cyc_t c;
    c.chk = 1'b1;  c.rst = 1'b0;  c.ack = 1'b0;  c.rdata = 8'h00; c.bus = 8'h00;
    c.req = 1'b0;  c.addr = m_pc; c.ren = 1'b0;  c.wen = 1'b0;    c.sel = 3'd0;
    c.wdata = 8'h00; c.od = m_od; c.ov = m_ov_pending; c.hlt = m_hlt; c.ill = m_ill;
    return c;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_od = 8'h00; m_ov_pending = 1'b0; m_hlt = 1'b0; m_ill = 1'b0;
  endtask

  task automatic push(input bit req, input bit ren, input bit wen, input logic [2:0] sel,
                      input logic [7:0] wdata, input bit ack, input logic [7:0] bus);
    cyc_t c = snap();
    c.req = req; c.ren = ren; c.wen = wen; c.sel = sel; c.wdata = wdata;
    c.ack = ack; c.bus = bus;
    c.rdata = (req && ack) ? mem[m_pc] : rnd();
    m_ov_pending = 1'b0;
    q.push_back(c);
  endtask

  task automatic fetch_byte(input int waits, output logic [7:0] b);
    repeat (waits) push(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, rnd());
    b = mem[m_pc];
    push(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, rnd());
    m_pc = m_pc + 8'd1;
  endtask

  // Expand one instruction at the model pc; spur drives stray acks while no request is up.
  task automatic gen_instr(input int wf, input int wo, input bit spur);
    logic [7:0] ir, opnd, bus;
    logic [2:0] r;
    fetch_byte(wf, ir);
    r = ir[4:2];
    push(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, spur, rnd());
    case (ir[7:5])
      3'b000: ;
      3'b001: begin
        fetch_byte(wo, opnd);
        push(1'b0, 1'b0, 1'b1, r, opnd, spur, rnd());
      end
      3'b011: begin
        fetch_byte(wo, opnd);
        push(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, spur, rnd());
        m_pc = opnd;
      end
      3'b010: begin
        bus = rnd();
        push(1'b0, 1'b1, 1'b0, r, 8'h00, spur, bus);
        m_od = bus;
        m_ov_pending = 1'b1;
      end
      3'b111:  m_hlt = 1'b1;
      default: m_ill = 1'b1;
    endcase
  endtask

  task automatic halt_cycles(input int n);
    repeat (n) push(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, bit'($urandom), rnd());
  endtask

  // Replace trace entry idx (and anything after it) by a reset cycle; registers still hold
  // their pre-reset values in that cycle, only the request/enable outputs drop.
  task automatic reset_at(input int idx);
    cyc_t c;
    if (idx < q.size()) begin
      c = q[idx];
      while (q.size() > idx) void'(q.pop_back());
    end else begin
      c = snap();
    end
    c.chk = 1'b1; c.rst = 1'b1; c.req = 1'b0; c.ren = 1'b0; c.wen = 1'b0;
    c.sel = 3'd0; c.wdata = 8'h00; c.ack = 1'b1; c.rdata = rnd(); c.bus = rnd();
    q.push_back(c);
    model_reset();
  endtask

  task automatic run_trace();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      rst = c.rst; mem_ack = c.ack; mem_rdata = c.rdata; bus_in = c.bus;
      #1;
      if (c.chk) begin
        check("mem_req",   32'(mem_req),   32'(c.req));
        check("mem_addr",  32'(mem_addr),  32'(c.addr));
        check("reg_ren",   32'(reg_ren),   32'(c.ren));
        check("reg_wen",   32'(reg_wen),   32'(c.wen));
        check("reg_sel",   32'(reg_sel),   32'(c.sel));
        check("reg_wdata", 32'(reg_wdata), 32'(c.wdata));
        check("out_data",  32'(out_data),  32'(c.od));
        check("out_valid", 32'(out_valid), 32'(c.ov));
        check("halted",    32'(halted),    32'(c.hlt));
        check("illegal",   32'(illegal),   32'(c.ill));
      end
      cyc++;
    end
  endtask

  initial begin
    cyc_t c;
    int   base;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    model_reset();
    c = snap(); c.chk = 1'b0; c.rst = 1'b1; c.ack = 1'b1;
    q.push_back(c);
    q.push_back(c);

    // LDI r1,0x5A; OUT r1; JMP 0xFE; JMP 0x10 from 0xFE/0xFF; NOP at 0x10.
    mem[8'h00] = 8'h24; mem[8'h01] = 8'h5A; mem[8'h02] = 8'h44;
    mem[8'h03] = 8'h60; mem[8'h04] = 8'hFE;
    mem[8'hFE] = 8'h60; mem[8'hFF] = 8'h10; mem[8'h10] = 8'h00;
    repeat (5) gen_instr(0, 0, 1'b0);
    gen_instr(0, 0, 1'b0);
    run_trace();

    // NOP at 0xFF wraps the pc to 0x00.
    mem[8'h00] = 8'h60; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h00;
    reset_at(q.size());
    repeat (3) gen_instr(0, 0, 1'b1);
    run_trace();

    // LDI with three wait cycles on both fetch and operand, stray ack during DECODE.
    mem[8'h00] = 8'h24; mem[8'h01] = 8'h33;
    reset_at(q.size());
    gen_instr(3, 3, 1'b1);
    run_trace();

    // Illegal opcode then HLT; halt holds with no requests until reset.
    mem[8'h00] = 8'hA0; mem[8'h01] = 8'hE0;
    reset_at(q.size());
    gen_instr(0, 0, 1'b1);
    gen_instr(0, 0, 1'b1);
    halt_cycles(20);
    reset_at(q.size());
    gen_instr(0, 0, 1'b0);
    run_trace();

    // Reset in the middle of an operand wait, then again right after an OUT.
    mem[8'h00] = 8'h28; mem[8'h01] = 8'h77;
    reset_at(q.size());
    base = q.size();
    gen_instr(0, 5, 1'b0);
    reset_at(base + 4);
    gen_instr(0, 0, 1'b0);
    mem[8'h02] = 8'h4C;
    gen_instr(1, 0, 1'b0);
    reset_at(q.size());
    gen_instr(0, 0, 1'b0);
    run_trace();

    // Random programs, random wait states and occasional mid-instruction resets.
    for (int i = 0; i < 256; i++) mem[i] = rnd();
    reset_at(q.size());
    for (int n = 0; n < 300; n++) begin
      base = q.size();
      gen_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bit'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        reset_at(base + int'($urandom_range(0, q.size() - base)));
      end else if (m_hlt) begin
        halt_cycles(int'($urandom_range(1, 5)));
        reset_at(q.size());
      end
      if (q.size() > 64) run_trace();
    end
    run_trace();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
